vhist_tap_reader: RTL and testbench

- Stores the most recent DEPTH signed membrane-voltage samples in a circular history.
- Serves random-access tap reads over a request/response valid-ready handshake.
- It is the read-side counterpart of the fixed-delay voltage delay line: the neuron core writes one sample per valid cycle, and downstream logic (STDP/refractory/plot taps) fetches any past sample by delay index.

---
 rtl/neuron_pkg.sv | 13 +
 rtl/vhist_ring.sv | 71 +++++++
 rtl/vhist_tap_reader.sv | 94 +++++++++
 tb/tb_vhist_tap_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared neuron-core types: voltage sample width/type and the tap-reader response FSM states.
package neuron_pkg;

    localparam int unsigned V_WIDTH = 21;

    typedef logic signed [V_WIDTH-1:0] v_sample_t;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_HOLD = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/vhist_ring.sv
// Circular voltage history: storage, write pointer, fill count, flush, pre-write tap read.
// VHIST_OLDEST_TAP_EN adds a registered eviction pulse carrying the overwritten sample.
module vhist_ring
    import neuron_pkg::*;
#(
    parameter  int unsigned WIDTH = V_WIDTH,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] i_wdata,
    input  logic                    i_wvalid,
    input  logic                    i_flush,
    input  logic        [AW-1:0]    i_tap,
`ifdef VHIST_OLDEST_TAP_EN
    output logic                    o_evict_valid,
    output logic signed [WIDTH-1:0] o_evict_data,
`endif
    output logic signed [WIDTH-1:0] o_tap_data,
    output logic        [AW:0]      o_fill
);

    logic signed [WIDTH-1:0] r_mem [DEPTH];
    logic        [AW-1:0]    r_wptr;
    logic        [AW:0]      r_fill;
    logic                    w_we;
    logic                    w_full;
    logic        [AW-1:0]    w_tap_addr;

    assign w_we       = i_wvalid & ~i_flush;
    assign w_full     = (r_fill == (AW+1)'(DEPTH));
    // Tap is read from registered state, so a same-cycle write never moves it.
    assign w_tap_addr = r_wptr - AW'(1) - i_tap;
    assign o_tap_data = r_mem[w_tap_addr];
    assign o_fill     = r_fill;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (w_we) begin
            r_wptr <= r_wptr + 1'b1;
            r_fill <= w_full ? r_fill : r_fill + 1'b1;
        end
    end

`ifdef VHIST_OLDEST_TAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_evict_valid <= 1'b0;
            o_evict_data  <= '0;
        end else begin
            o_evict_valid <= w_we & w_full;
            if (w_we & w_full) begin
                o_evict_data <= r_mem[r_wptr];
            end
        end
    end
`endif

endmodule

// File: rtl/vhist_tap_reader.sv
// Random-access tap reader over a DEPTH-sample voltage history with a 1-cycle valid/ready response.
// VHIST_OLDEST_TAP_EN exposes evict_valid/evict_data (fixed DEPTH-sample delay output).
module vhist_tap_reader
    import neuron_pkg::*;
#(
    parameter  int unsigned WIDTH = V_WIDTH,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    in_valid,
    input  logic                    flush,
    input  logic                    rd_req,
    input  logic        [AW-1:0]    rd_delay,
    output logic                    req_ready,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic signed [WIDTH-1:0] rd_data,
    output logic                    rd_oor,
`ifdef VHIST_OLDEST_TAP_EN
    output logic                    evict_valid,
    output logic signed [WIDTH-1:0] evict_data,
`endif
    output logic        [AW:0]      fill
);

    rsp_state_t              r_state;
    rsp_state_t              w_state_next;
    logic signed [WIDTH-1:0] r_data;
    logic                    r_oor;
    logic signed [WIDTH-1:0] w_tap_data;
    logic        [AW:0]      w_fill;
    logic                    w_accept;
    logic                    w_in_range;

    vhist_ring #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wdata       (in),
        .i_wvalid      (in_valid),
        .i_flush       (flush),
        .i_tap         (rd_delay),
`ifdef VHIST_OLDEST_TAP_EN
        .o_evict_valid (evict_valid),
        .o_evict_data  (evict_data),
`endif
        .o_tap_data    (w_tap_data),
        .o_fill        (w_fill)
    );

    assign fill       = w_fill;
    assign rd_valid   = (r_state == RSP_HOLD);
    assign req_ready  = ~rd_valid | rd_ready;
    assign w_accept   = rd_req & req_ready;
    assign w_in_range = ({1'b0, rd_delay} < w_fill);
    assign rd_data    = r_data;
    assign rd_oor     = r_oor;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RSP_IDLE: if (w_accept) w_state_next = RSP_HOLD;
            RSP_HOLD: begin
                if (w_accept)      w_state_next = RSP_HOLD;
                else if (rd_ready) w_state_next = RSP_IDLE;
            end
            default:  w_state_next = RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RSP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_oor  <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_in_range ? w_tap_data : '0;
            r_oor  <= ~w_in_range;
        end
    end

endmodule

// File: tb/tb_vhist_tap_reader.sv
// Self-checking bench for vhist_tap_reader: directed vector table plus randomized run against a queue model.
module tb_vhist_tap_reader;
    import neuron_pkg::*;

    localparam int W  = 21;
    localparam int D  = 8;
    localparam int AW = 3;

    logic                clk;
    logic                rst_n;
    logic signed [W-1:0] din;
    logic                in_valid;
    logic                flush;
    logic                rd_req;
    logic [AW-1:0]       rd_delay;
    logic                req_ready;
    logic                rd_valid;
    logic                rd_ready;
    logic signed [W-1:0] rd_data;
    logic                rd_oor;
    logic [AW:0]         fill;
`ifdef VHIST_OLDEST_TAP_EN
    logic                evict_valid;
    logic signed [W-1:0] evict_data;
`endif

    vhist_tap_reader #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (din),
        .in_valid    (in_valid),
        .flush       (flush),
        .rd_req      (rd_req),
        .rd_delay    (rd_delay),
        .req_ready   (req_ready),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_oor      (rd_oor),
`ifdef VHIST_OLDEST_TAP_EN
        .evict_valid (evict_valid),
        .evict_data  (evict_data),
`endif
        .fill        (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit ivld; int din; bit fl; bit req; int dly; bit rdy;
        bit e_rr; bit e_v; int e_d; bit e_oor; int e_fill;
    } vec_t;

    vec_t tab[40];
    int   ntab;
    int   checks;
    int   errors;

    // Reference model: newest sample at index 0, oldest at the back.
    int hist[$];
    bit m_valid;
    int m_data;
    bit m_oor;
    bit m_ev_valid;
    int m_ev_data;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic put(input bit iv, input int dv, input bit fl, input bit rq, input int dl,
                       input bit ry, input bit err, input bit ev, input int ed, input bit eo,
                       input int ef);
        tab[ntab] = '{iv, dv, fl, rq, dl, ry, err, ev, ed, eo, ef};
        ntab++;
    endtask

    task automatic model_reset();
        hist.delete();
        m_valid    = 1'b0;
        m_data     = 0;
        m_oor      = 1'b0;
        m_ev_valid = 1'b0;
        m_ev_data  = 0;
    endtask

    task automatic step(input vec_t v, input bit use_tab);
        bit ready;
        in_valid = v.ivld;
        din      = W'(v.din);
        flush    = v.fl;
        rd_req   = v.req;
        rd_delay = AW'(v.dly);
        rd_ready = v.rdy;
        #1;
        ready = !m_valid || v.rdy;
        chk("req_ready", int'(req_ready), int'(ready));
        if (use_tab) chk("tab_req_ready", int'(req_ready), int'(v.e_rr));

        if (v.req && ready) begin
            m_valid = 1'b1;
            if (v.dly < hist.size()) begin
                m_data = hist[v.dly];
                m_oor  = 1'b0;
            end else begin
                m_data = 0;
                m_oor  = 1'b1;
            end
        end else if (m_valid && v.rdy) begin
            m_valid = 1'b0;
        end
        m_ev_valid = 1'b0;
        if (v.fl) begin
            hist.delete();
        end else if (v.ivld) begin
            hist.push_front(int'(din));
            if (hist.size() > D) begin
                m_ev_data  = hist.pop_back();
                m_ev_valid = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        chk("rd_valid", int'(rd_valid), int'(m_valid));
        if (m_valid) begin
            chk("rd_data", int'(rd_data), m_data);
            chk("rd_oor", int'(rd_oor), int'(m_oor));
        end
        chk("fill", int'(fill), hist.size());
`ifdef VHIST_OLDEST_TAP_EN
        chk("evict_valid", int'(evict_valid), int'(m_ev_valid));
        if (m_ev_valid) chk("evict_data", int'(evict_data), m_ev_data);
`endif
        if (use_tab) begin
            chk("tab_rd_valid", int'(rd_valid), int'(v.e_v));
            if (v.e_v) begin
                chk("tab_rd_data", int'(rd_data), v.e_d);
                chk("tab_rd_oor", int'(rd_oor), int'(v.e_oor));
            end
            chk("tab_fill", int'(fill), v.e_fill);
        end
    endtask

    initial begin
        vec_t           rv;
        v_sample_t      s;
        checks = 0;
        errors = 0;
        ntab   = 0;

        // Directed vectors: {ivld,din,fl,req,dly,rdy | req_ready,valid,data,oor,fill}
        put(0, 0, 0, 1, 0, 1,  1, 1, 0, 1, 0);
        put(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0);
        put(1, 10, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        put(1, 20, 0, 0, 0, 1, 1, 0, 0, 0, 2);
        put(1, 30, 0, 0, 0, 1, 1, 0, 0, 0, 3);
        put(0, 0, 0, 1, 0, 1,  1, 1, 30, 0, 3);
        put(0, 0, 0, 1, 2, 1,  1, 1, 10, 0, 3);
        put(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 3);
        put(0, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) put(1, i, 0, 0, 0, 1, 1, 0, 0, 0, (i < 8) ? i : 8);
        put(0, 0, 0, 1, 0, 1,  1, 1, 10, 0, 8);
        put(0, 0, 0, 1, 7, 1,  1, 1, 3, 0, 8);
        put(1, 5, 0, 0, 0, 1,  1, 0, 0, 0, 8);
        put(1, 99, 0, 1, 0, 1, 1, 1, 5, 0, 8);
        put(0, 0, 0, 1, 0, 1,  1, 1, 99, 0, 8);
        for (int i = 1; i <= 4; i++) put(1, i, 0, 1, 1, 0, 0, 1, 99, 0, 8);
        put(0, 0, 0, 1, 0, 1,  1, 1, 4, 0, 8);
        put(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 8);
        put(1, 77, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        put(0, 0, 0, 1, 0, 0,  1, 1, 0, 1, 0);

        rst_n    = 1'b0;
        din      = '0;
        in_valid = 1'b0;
        flush    = 1'b0;
        rd_req   = 1'b0;
        rd_delay = '0;
        rd_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_rd_oor", int'(rd_oor), 0);
        chk("reset_fill", int'(fill), 0);
        chk("reset_req_ready", int'(req_ready), 1);
        rst_n = 1'b1;

        for (int i = 0; i < ntab; i++) step(tab[i], 1'b1);

        // Asynchronous reset while a response is pending clears it without a clock edge.
        chk("pre_reset_rd_valid", int'(rd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_rd_valid", int'(rd_valid), 0);
        chk("async_reset_rd_oor", int'(rd_oor), 0);
        chk("async_reset_fill", int'(fill), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            s       = W'($urandom);
            rv.ivld = ($urandom_range(0, 1) == 1);
            rv.din  = int'(s);
            rv.fl   = ($urandom_range(0, 15) == 0);
            rv.req  = ($urandom_range(0, 3) != 0);
            rv.dly  = int'($urandom_range(0, D - 1));
            rv.rdy  = ($urandom_range(0, 2) != 0);
            rv.e_rr = 1'b0; rv.e_v = 1'b0; rv.e_d = 0; rv.e_oor = 1'b0; rv.e_fill = 0;
            step(rv, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
